// File: rtl/conv_pkg.sv
// Shared constants and window packing helpers for the 3x3 convolution window generator.
package conv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned WIN_DIM        = 3;
  localparam int unsigned WIN_ELEMS      = WIN_DIM * WIN_DIM;

  // Flat element index of window position (i, j); i=0 is the oldest row, j=0 the leftmost column.
  function automatic int unsigned win_idx(input int unsigned i, input int unsigned j);
    return i * WIN_DIM + j;
  endfunction

endpackage

// File: rtl/line_buffer_rw.sv
// Circular line buffer: combinational read at the pointer, synchronous write of din, pointer advances on en.
module line_buffer_rw #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 28,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
      else                          ptr <= ptr + 1'b1;
    end
  end

  // Storage is deliberately left unreset; stale contents never reach an emitted window.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, with a single registered valid/ready output stage.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
  parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data,
  output logic                            frame_done
);

  logic                  accept;
  logic [DATA_WIDTH-1:0] lb0_q;
  logic [DATA_WIDTH-1:0] lb1_q;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  last_col;
  logic                  last_row;
  logic                  emit;

  logic [DATA_WIDTH-1:0]           win_q   [WIN_DIM][WIN_DIM];
  logic [DATA_WIDTH-1:0]           win_nxt [WIN_DIM][WIN_DIM];
  logic [WIN_ELEMS*DATA_WIDTH-1:0] win_pack;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
  assign emit     = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  line_buffer_rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .PTR_W      (COL_W)
  ) u_lb0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (in_data),
    .dout  (lb0_q)
  );

  line_buffer_rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .PTR_W      (COL_W)
  ) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .din   (lb0_q),
    .dout  (lb1_q)
  );

  // Post-shift window: rows slide left, new right column is {two rows ago, one row ago, current}.
  always_comb begin
    for (int unsigned i = 0; i < WIN_DIM; i++) begin
      for (int unsigned j = 0; j < WIN_DIM - 1; j++) begin
        win_nxt[i][j] = win_q[i][j+1];
      end
    end
    win_nxt[0][WIN_DIM-1] = lb1_q;
    win_nxt[1][WIN_DIM-1] = lb0_q;
    win_nxt[2][WIN_DIM-1] = in_data;
  end

  always_comb begin
    win_pack = '0;
    for (int unsigned i = 0; i < WIN_DIM; i++) begin
      for (int unsigned j = 0; j < WIN_DIM; j++) begin
        win_pack[win_idx(i, j)*DATA_WIDTH +: DATA_WIDTH] = win_nxt[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIN_DIM; i++) begin
        for (int unsigned j = 0; j < WIN_DIM; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < WIN_DIM; i++) begin
        for (int unsigned j = 0; j < WIN_DIM; j++) begin
          win_q[i][j] <= win_nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // An idle cycle with win_ready high retires the held window so it is never presented twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
    end else if (accept && emit) begin
      win_valid <= 1'b1;
      win_data  <= win_pack;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 4x4 frame scenarios plus a 28x28 random frame against a frame-array model.
module tb_conv_window_gen;

  logic        clk;
  logic        rst_n;

  logic        in_valid_a, in_ready_a, win_valid_a, win_ready_a, frame_done_a;
  logic [7:0]  in_data_a;
  logic [71:0] win_data_a;

  logic        in_valid_b, in_ready_b, win_valid_b, win_ready_b, frame_done_b;
  logic [7:0]  in_data_b;
  logic [71:0] win_data_b;

  int checks = 0;
  int errors = 0;

  logic [71:0] got_a[$];
  logic [71:0] got_b[$];
  int          fd_a = 0;
  int          stall_req = 0;
  int          stall_done = 0;
  logic [7:0]  pix_b [784];

  conv_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_data    (in_data_a),
    .win_valid  (win_valid_a),
    .win_ready  (win_ready_a),
    .win_data   (win_data_a),
    .frame_done (frame_done_a)
  );

  conv_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data_b),
    .win_valid  (win_valid_b),
    .win_ready  (win_ready_b),
    .win_data   (win_data_b),
    .frame_done (frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Window centred at (cr, cc) of a 4x4 frame whose pixel (r, c) is base + r*4 + c.
  function automatic logic [71:0] exp_win(input int base, input int cr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = 8'(base + (cr - 1 + i) * 4 + (cc - 1 + j));
    return w;
  endfunction

  function automatic logic [71:0] exp_win_b(input int cr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = pix_b[(cr - 1 + i) * 28 + (cc - 1 + j)];
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && win_valid_a && win_ready_a) got_a.push_back(win_data_a);
    if (rst_n && win_valid_b && win_ready_b) got_b.push_back(win_data_b);
    if (frame_done_a) fd_a++;
  end

  // Holds win_ready low for three cycles on the first window presented after each stall request.
  initial begin
    logic [71:0] held;
    win_ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_done < stall_req && win_valid_a) begin
        held        = win_data_a;
        win_ready_a = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_data", win_data_a, held);
          check("stall_valid", 72'(win_valid_a), 72'd1);
          check("stall_in_ready", 72'(in_ready_a), 72'd0);
        end
        @(posedge clk);
        #1;
        win_ready_a = 1'b1;
        stall_done++;
      end
    end
  end

  task automatic send_a(input int base, input bit gaps, input bit lat, input int count);
    bit acc;
    int t;
    for (int k = 0; k < count; k++) begin
      if (gaps) begin
        in_valid_a = 1'b0;
        repeat ($urandom_range(1, 0)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data_a  = 8'(base + k);
      in_valid_a = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        acc = in_valid_a && in_ready_a;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 100);
      in_valid_a = 1'b0;
      if (!acc) begin
        check("accept_timeout", 72'd0, 72'd1);
        return;
      end
      if (lat) begin
        check("lat_valid", 72'(win_valid_a), 72'((k / 4 >= 2) && (k % 4 >= 2)));
        if ((k / 4 >= 2) && (k % 4 >= 2))
          check("lat_data", win_data_a, exp_win(base, k / 4 - 1, k % 4 - 1));
        check("frame_done_pulse", 72'(frame_done_a), 72'(k == 15));
      end
    end
  endtask

  task automatic check_seq(input string tag, input int n0, input int base);
    for (int w = 0; w < 4; w++) begin
      if (n0 + w < got_a.size()) check(tag, got_a[n0 + w], exp_win(base, 1 + w / 2, 1 + w % 2));
      else                       check(tag, 72'hx, exp_win(base, 1 + w / 2, 1 + w % 2));
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int f0;
    bit acc;
    int t;

    rst_n      = 1'b0;
    in_valid_a = 1'b0;
    in_data_a  = '0;
    in_valid_b = 1'b0;
    in_data_b  = '0;
    win_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_valid", 72'(win_valid_a), 72'd0);
    check("rst_win_data", win_data_a, 72'd0);
    check("rst_frame_done", 72'(frame_done_a), 72'd0);
    check("rst_in_ready", 72'(in_ready_a), 72'd1);
    check("rst_b_win_valid", 72'(win_valid_b), 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Gapless frame, win_ready held high
    n0 = got_a.size();
    f0 = fd_a;
    send_a(0, 1'b0, 1'b1, 16);
    drain();
    check("s1_count", 72'(got_a.size() - n0), 72'd4);
    check("s1_first", got_a[n0], {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    check("s1_last", got_a[n0 + 3], {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
    check("s1_frame_done_cnt", 72'(fd_a - f0), 72'd1);
    check_seq("s1_seq", n0, 0);

    // Backpressure on the first window
    n0 = got_a.size();
    stall_req = 1;
    send_a(0, 1'b0, 1'b0, 16);
    drain();
    check("s2_stalled", 72'(stall_done), 72'd1);
    check("s2_count", 72'(got_a.size() - n0), 72'd4);
    check_seq("s2_seq", n0, 0);

    // Random input gaps
    n0 = got_a.size();
    send_a(0, 1'b1, 1'b1, 16);
    drain();
    check("s3_count", 72'(got_a.size() - n0), 72'd4);
    check_seq("s3_seq", n0, 0);

    // Back-to-back frames
    n0 = got_a.size();
    f0 = fd_a;
    send_a(0, 1'b0, 1'b1, 16);
    send_a(100, 1'b0, 1'b1, 16);
    drain();
    check("s4_count", 72'(got_a.size() - n0), 72'd8);
    check_seq("s4_seq_f1", n0, 0);
    check_seq("s4_seq_f2", n0 + 4, 100);
    check("s4_f2_first", got_a[n0 + 4],
          {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
    check("s4_frame_done_cnt", 72'(fd_a - f0), 72'd2);

    // Reset mid-frame after pixel 9
    send_a(0, 1'b0, 1'b1, 10);
    rst_n = 1'b0;
    #1;
    check("s5_rst_win_valid", 72'(win_valid_a), 72'd0);
    check("s5_rst_win_data", win_data_a, 72'd0);
    check("s5_rst_frame_done", 72'(frame_done_a), 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = got_a.size();
    send_a(0, 1'b0, 1'b1, 16);
    drain();
    check("s5_count", 72'(got_a.size() - n0), 72'd4);
    check_seq("s5_seq", n0, 0);

    // Full-size random frame against the frame-array model
    for (int k = 0; k < 784; k++) pix_b[k] = 8'($urandom);
    for (int k = 0; k < 784; k++) begin
      in_data_b  = pix_b[k];
      in_valid_b = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        acc = in_valid_b && in_ready_b;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 100);
      if (!acc) begin
        check("b_accept_timeout", 72'd0, 72'd1);
        break;
      end
    end
    in_valid_b = 1'b0;
    drain();
    check("b_count", 72'(got_b.size()), 72'd676);
    for (int w = 0; w < 676; w++) begin
      if (w < got_b.size()) check("b_win", got_b[w], exp_win_b(1 + w / 26, 1 + w % 26));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
